// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU/writeback selectors
// and the load-extension helper used by the core.
package riscv_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_LOAD,
        WB_PC4
    } wb_sel_e;

    // Map funct3 to an ALU op; alt selects SUB/SRA (inst[30]).
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Pick the addressed byte/halfword out of an aligned word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h000000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_core_regfile.sv
// 32x32 architectural register file: two combinational reads, one write.
// x0 always reads zero and ignores writes.
module regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs [0:31];

    // Clear all registers on reset, otherwise commit the write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0000_0000 : regs[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0000_0000 : regs[raddr_b_i];

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core. Decode, ALU, immediates and load/store lane
// handling live here; architectural state is the PC and the register file.
module riscv_core
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wmask,
    output logic        data_wen,
    input  logic [31:0] data_rdata
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_s;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

    logic [31:0] rs1_data_s, rs2_data_s;
    logic [31:0] alu_a_s, alu_b_s, alu_res_s;
    alu_op_e     alu_op_s;
    wb_sel_e     wb_sel_s;
    logic        rd_we_s, is_store_s, is_branch_s, is_jal_s, is_jalr_s;
    logic        br_taken_s;
    logic [31:0] wb_data_s;
    logic [31:0] wdata_s;
    logic [3:0]  wmask_s;
    logic        op_legal_s, op_imm_legal_s;

    assign opcode_s = inst[6:0];
    assign rd_s     = inst[11:7];
    assign funct3_s = inst[14:12];
    assign rs1_s    = inst[19:15];
    assign rs2_s    = inst[24:20];
    assign funct7_s = inst[31:25];

    assign imm_i_s = {{20{inst[31]}}, inst[31:20]};
    assign imm_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u_s = {inst[31:12], 12'h000};
    assign imm_j_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign pc_plus4_s = pc_q + 32'd4;
    assign inst_addr  = pc_q;

    // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
    assign op_legal_s = (funct7_s == 7'b0000000) ||
                        ((funct7_s == 7'b0100000) &&
                         ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
    assign op_imm_legal_s = (funct3_s == 3'b001) ? (funct7_s == 7'b0000000) :
                            (funct3_s == 3'b101) ? ((funct7_s == 7'b0000000) ||
                                                    (funct7_s == 7'b0100000)) :
                            1'b1;

    regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .raddr_a_i (rs1_s),
        .raddr_b_i (rs2_s),
        .rdata_a_o (rs1_data_s),
        .rdata_b_o (rs2_data_s),
        .we_i      (rd_we_s & ~rst),
        .waddr_i   (rd_s),
        .wdata_i   (wb_data_s)
    );

    // Decode: choose ALU operands/op, writeback source and control flags.
    // Anything not recognised falls through with all enables low (a NOP).
    always_comb begin
        alu_op_s    = ALU_ADD;
        alu_a_s     = rs1_data_s;
        alu_b_s     = imm_i_s;
        wb_sel_s    = WB_ALU;
        rd_we_s     = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                alu_a_s = 32'h0000_0000;
                alu_b_s = imm_u_s;
                rd_we_s = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a_s = pc_q;
                alu_b_s = imm_u_s;
                rd_we_s = 1'b1;
            end
            OPC_JAL: begin
                wb_sel_s = WB_PC4;
                rd_we_s  = 1'b1;
                is_jal_s = 1'b1;
            end
            OPC_JALR: begin
                if (funct3_s == 3'b000) begin
                    wb_sel_s  = WB_PC4;
                    rd_we_s   = 1'b1;
                    is_jalr_s = 1'b1;
                end else begin
                    rd_we_s = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if ((funct3_s != 3'b010) && (funct3_s != 3'b011)) begin
                    is_branch_s = 1'b1;
                end else begin
                    is_branch_s = 1'b0;
                end
            end
            OPC_LOAD: begin
                if ((funct3_s == F3_B) || (funct3_s == F3_H) || (funct3_s == F3_W) ||
                    (funct3_s == F3_BU) || (funct3_s == F3_HU)) begin
                    wb_sel_s = WB_LOAD;
                    rd_we_s  = 1'b1;
                end else begin
                    rd_we_s = 1'b0;
                end
            end
            OPC_STORE: begin
                alu_b_s = imm_s_s;
                if ((funct3_s == F3_B) || (funct3_s == F3_H) || (funct3_s == F3_W)) begin
                    is_store_s = 1'b1;
                end else begin
                    is_store_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (op_imm_legal_s) begin
                    alu_op_s = alu_from_f3(funct3_s, (funct3_s == 3'b101) & inst[30]);
                    rd_we_s  = 1'b1;
                end else begin
                    rd_we_s = 1'b0;
                end
            end
            OPC_OP: begin
                alu_b_s = rs2_data_s;
                if (op_legal_s) begin
                    alu_op_s = alu_from_f3(funct3_s, inst[30]);
                    rd_we_s  = 1'b1;
                end else begin
                    rd_we_s = 1'b0;
                end
            end
            default: begin
                rd_we_s = 1'b0;
            end
        endcase
    end

    // ALU: all arithmetic wraps modulo 2^32, shifts use the low five bits.
    always_comb begin
        case (alu_op_s)
            ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
            ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
            ALU_SLL:  alu_res_s = alu_a_s << alu_b_s[4:0];
            ALU_SLT:  alu_res_s = {31'd0, $signed(alu_a_s) < $signed(alu_b_s)};
            ALU_SLTU: alu_res_s = {31'd0, alu_a_s < alu_b_s};
            ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
            ALU_SRL:  alu_res_s = alu_a_s >> alu_b_s[4:0];
            ALU_SRA:  alu_res_s = $unsigned($signed(alu_a_s) >>> alu_b_s[4:0]);
            ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
            ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
            default:  alu_res_s = alu_a_s + alu_b_s;
        endcase
    end

    // Branch condition from the two register operands.
    always_comb begin
        case (funct3_s)
            F3_BEQ:  br_taken_s = (rs1_data_s == rs2_data_s);
            F3_BNE:  br_taken_s = (rs1_data_s != rs2_data_s);
            F3_BLT:  br_taken_s = ($signed(rs1_data_s) < $signed(rs2_data_s));
            F3_BGE:  br_taken_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
            F3_BLTU: br_taken_s = (rs1_data_s < rs2_data_s);
            F3_BGEU: br_taken_s = (rs1_data_s >= rs2_data_s);
            default: br_taken_s = 1'b0;
        endcase
    end

    // Next PC: jumps and taken branches redirect, JALR clears bit 0.
    always_comb begin
        if (is_jal_s) begin
            pc_d = pc_q + imm_j_s;
        end else if (is_branch_s && br_taken_s) begin
            pc_d = pc_q + imm_b_s;
        end else if (is_jalr_s) begin
            pc_d = alu_res_s & 32'hFFFF_FFFE;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // Writeback source select.
    always_comb begin
        case (wb_sel_s)
            WB_ALU:  wb_data_s = alu_res_s;
            WB_LOAD: wb_data_s = load_extend(funct3_s, alu_res_s[1:0], data_rdata);
            WB_PC4:  wb_data_s = pc_plus4_s;
            default: wb_data_s = alu_res_s;
        endcase
    end

    // Store lane steering: replicate data, enable only the addressed lanes.
    // Reset suppresses the mask so an in-flight store never commits.
    always_comb begin
        wdata_s = rs2_data_s;
        wmask_s = 4'b0000;
        if (is_store_s && !rst) begin
            case (funct3_s)
                F3_B: begin
                    wdata_s = {4{rs2_data_s[7:0]}};
                    wmask_s = 4'b0001 << alu_res_s[1:0];
                end
                F3_H: begin
                    wdata_s = {2{rs2_data_s[15:0]}};
                    wmask_s = alu_res_s[1] ? 4'b1100 : 4'b0011;
                end
                F3_W: begin
                    wdata_s = rs2_data_s;
                    wmask_s = 4'b1111;
                end
                default: begin
                    wmask_s = 4'b0000;
                end
            endcase
        end else begin
            wmask_s = 4'b0000;
        end
    end

    assign data_addr  = alu_res_s;
    assign data_wdata = wdata_s;
    assign data_wmask = wmask_s;
    assign data_wen   = (wmask_s != 4'b0000);

    // PC register: back to zero on reset, otherwise follow next-PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Directed-program bench for riscv_core. Stores are checked by a
// scoreboard monitor; register/memory state is checked after each program.
module tb_riscv_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr, inst, data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wmask;
    logic        data_wen;
    logic        clr_dmem = 1'b0;

    logic [31:0] imem [0:63];
    logic [7:0]  dmem [0:255];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } st_t;

    st_t exp_q [$];
    int  checks = 0;
    int  errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    riscv_core dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_wmask (data_wmask),
        .data_wen   (data_wen),
        .data_rdata (data_rdata)
    );

    assign inst       = imem[inst_addr[7:2]];
    assign data_rdata = {dmem[{data_addr[7:2], 2'b11}], dmem[{data_addr[7:2], 2'b10}],
                         dmem[{data_addr[7:2], 2'b01}], dmem[{data_addr[7:2], 2'b00}]};

    // Data memory model: byte-masked synchronous write.
    always @(posedge clk) begin
        if (clr_dmem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
        end else if (data_wen) begin
            if (data_wmask[0]) dmem[{data_addr[7:2], 2'b00}] <= data_wdata[7:0];
            if (data_wmask[1]) dmem[{data_addr[7:2], 2'b01}] <= data_wdata[15:8];
            if (data_wmask[2]) dmem[{data_addr[7:2], 2'b10}] <= data_wdata[23:16];
            if (data_wmask[3]) dmem[{data_addr[7:2], 2'b11}] <= data_wdata[31:24];
        end
    end

    // Store monitor: every strobe must match the next expected store.
    always @(negedge clk) begin
        if (data_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: addr=%h wdata=%h mask=%b with nothing expected",
                         data_addr, data_wdata, data_wmask);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                if (data_addr !== e.addr || data_wdata !== e.wdata || data_wmask !== e.mask) begin
                    errors++;
                    $display("FAIL store: got addr=%h wdata=%h mask=%b expected addr=%h wdata=%h mask=%b",
                             data_addr, data_wdata, data_wmask, e.addr, e.wdata, e.mask);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] op_imm(input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] op_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] ld(input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h03};
    endfunction
    function automatic logic [31:0] st(input int f3, input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] lui(input int rd, input int imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction
    function automatic logic [31:0] auipc(input int rd, input int imm20);
        return {imm20[19:0], rd[4:0], 7'h17};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h67};
    endfunction
    function automatic st_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_t s;
        s.addr = a; s.wdata = d; s.mask = m;
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int n);
        return dut.u_regfile.regs[n];
    endfunction

    function automatic logic [31:0] dword(input int a);
        return {dmem[a + 3], dmem[a + 2], dmem[a + 1], dmem[a]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    task automatic clear_dmem();
        clr_dmem = 1'b1;
        step(1);
        clr_dmem = 1'b0;
    endtask

    // Two reset edges, checking the reset-state outputs, then release.
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        chk("rst_inst_addr", inst_addr, 32'h0000_0000);
        chk("rst_data_wen", {31'd0, data_wen}, 32'h0000_0000);
        chk("rst_data_wmask", {28'd0, data_wmask}, 32'h0000_0000);
        rst = 1'b0;
    endtask

    task automatic load_basic();
        clear_imem();
        imem[0] = op_imm(0, 1, 0, 1);     // addi x1,x0,1
        imem[1] = op_imm(0, 2, 0, 2);     // addi x2,x0,2
        imem[2] = op_r(0, 0, 3, 1, 2);    // add  x3,x1,x2
        imem[3] = st(2, 3, 0, 0);         // sw   x3,0(x0)
        imem[4] = ld(2, 4, 0, 0);         // lw   x4,0(x0)
    endtask

    initial begin
        // ---- basic program ----
        rst = 1'b1;
        load_basic();
        clear_dmem();
        exp_q.push_back(mk_st(32'h0, 32'h0000_0003, 4'b1111));
        do_reset();
        step(20);
        chk("basic_x1", rf(1), 32'd1);
        chk("basic_x2", rf(2), 32'd2);
        chk("basic_x3", rf(3), 32'd3);
        chk("basic_x4", rf(4), 32'd3);
        chk("basic_mem0", dword(0), 32'h0000_0003);

        // ---- reset mid-run aborts the in-flight store ----
        rst = 1'b1;
        load_basic();
        clear_dmem();
        do_reset();
        step(3);
        chk("mid_pc_before", inst_addr, 32'h0000_000C);
        chk("mid_x3_before", rf(3), 32'd3);
        rst = 1'b1;
        step(1);
        chk("mid_pc_after", inst_addr, 32'h0000_0000);
        for (int i = 0; i < 32; i++) chk($sformatf("mid_x%0d_zero", i), rf(i), 32'h0);
        chk("mid_mem0_untouched", dword(0), 32'h0000_0000);
        exp_q.push_back(mk_st(32'h0, 32'h0000_0003, 4'b1111));
        rst = 1'b0;
        step(20);
        chk("mid_rerun_x4", rf(4), 32'd3);

        // ---- byte / half access ----
        rst = 1'b1;
        clear_imem();
        imem[0] = op_imm(0, 1, 0, 128);   // addi x1,x0,0x80
        imem[1] = st(0, 1, 0, 1);         // sb   x1,1(x0)
        imem[2] = ld(0, 2, 0, 1);         // lb   x2,1(x0)
        imem[3] = ld(4, 3, 0, 1);         // lbu  x3,1(x0)
        imem[4] = lui(4, 8);              // lui  x4,0x8
        imem[5] = op_imm(0, 4, 4, 1);     // addi x4,x4,1
        imem[6] = st(1, 4, 0, 2);         // sh   x4,2(x0)
        imem[7] = ld(1, 5, 0, 2);         // lh   x5,2(x0)
        imem[8] = ld(5, 6, 0, 2);         // lhu  x6,2(x0)
        imem[9] = ld(2, 7, 0, 0);         // lw   x7,0(x0)
        clear_dmem();
        exp_q.push_back(mk_st(32'h1, 32'h8080_8080, 4'b0010));
        exp_q.push_back(mk_st(32'h2, 32'h8001_8001, 4'b1100));
        do_reset();
        step(20);
        chk("lb_sext", rf(2), 32'hFFFF_FF80);
        chk("lbu_zext", rf(3), 32'h0000_0080);
        chk("lh_sext", rf(5), 32'hFFFF_8001);
        chk("lhu_zext", rf(6), 32'h0000_8001);
        chk("lw_merged", rf(7), 32'h8001_8000);

        // ---- branches and jumps ----
        rst = 1'b1;
        clear_imem();
        imem[0]  = op_imm(0, 5, 0, 5);    // addi x5,x0,5
        imem[1]  = op_imm(0, 2, 0, 5);    // addi x2,x0,5
        imem[2]  = br(0, 5, 2, 8);        // beq  x5,x2,+8
        imem[3]  = op_imm(0, 3, 0, 1);    // addi x3,x0,1 (skipped)
        imem[4]  = jal(1, 8);             // jal  x1,+8 @0x10
        imem[5]  = op_imm(0, 3, 0, 2);    // addi x3,x0,2 (skipped)
        imem[6]  = br(1, 5, 2, 8);        // bne  x5,x2,+8 (not taken)
        imem[7]  = op_imm(0, 6, 0, 7);    // addi x6,x0,7
        imem[8]  = op_imm(0, 7, 0, 49);   // addi x7,x0,0x31
        imem[9]  = jalr(8, 7, 0);         // jalr x8,0(x7) -> 0x30
        imem[10] = op_imm(0, 9, 0, 1);    // skipped
        imem[11] = op_imm(0, 9, 0, 2);    // skipped
        imem[12] = op_imm(0, 10, 0, 3);   // addi x10,x0,3
        imem[13] = st(2, 1, 0, 64);       // sw   x1,64(x0)
        exp_q.push_back(mk_st(32'h40, 32'h0000_0014, 4'b1111));
        do_reset();
        step(4);
        chk("jal_pc", inst_addr, 32'h0000_0018);
        chk("jal_link", rf(1), 32'h0000_0014);
        step(16);
        chk("beq_skip", rf(3), 32'h0);
        chk("bne_fall", rf(6), 32'd7);
        chk("jalr_link", rf(8), 32'h0000_0028);
        chk("jalr_skip", rf(9), 32'h0);
        chk("jalr_target", rf(10), 32'd3);
        chk("jal_store_mem", dword(64), 32'h0000_0014);

        // ---- arithmetic edges ----
        rst = 1'b1;
        clear_imem();
        imem[0]  = op_imm(0, 1, 0, 1);          // addi x1,x0,1
        imem[1]  = op_r(32, 0, 2, 0, 1);        // sub  x2,x0,x1
        imem[2]  = op_r(0, 2, 3, 2, 1);         // slt  x3,x2,x1
        imem[3]  = op_r(0, 3, 4, 2, 1);         // sltu x4,x2,x1
        imem[4]  = lui(5, 32'h80000);           // lui  x5,0x80000
        imem[5]  = op_imm(5, 6, 5, 32'h41F);    // srai x6,x5,31
        imem[6]  = op_imm(0, 0, 0, 5);          // addi x0,x0,5
        imem[7]  = op_imm(5, 7, 5, 31);         // srli x7,x5,31
        imem[8]  = op_imm(2, 8, 2, 0);          // slti x8,x2,0
        imem[9]  = op_imm(3, 9, 1, -1);         // sltiu x9,x1,-1
        imem[10] = op_imm(4, 10, 1, -1);        // xori x10,x1,-1
        imem[11] = auipc(11, 1);                // auipc x11,1 @0x2C
        imem[12] = op_imm(1, 12, 1, 4);         // slli x12,x1,4
        imem[13] = op_r(32, 5, 13, 5, 12);      // sra  x13,x5,x12
        imem[14] = op_r(0, 7, 14, 10, 13);      // and  x14,x10,x13
        do_reset();
        step(20);
        chk("sub_wrap", rf(2), 32'hFFFF_FFFF);
        chk("slt_signed", rf(3), 32'd1);
        chk("sltu_unsigned", rf(4), 32'd0);
        chk("srai_31", rf(6), 32'hFFFF_FFFF);
        chk("x0_const", rf(0), 32'h0);
        chk("srli_31", rf(7), 32'd1);
        chk("slti", rf(8), 32'd1);
        chk("sltiu", rf(9), 32'd1);
        chk("xori", rf(10), 32'hFFFF_FFFE);
        chk("auipc", rf(11), 32'h0000_102C);
        chk("slli", rf(12), 32'h0000_0010);
        chk("sra_reg", rf(13), 32'hFFFF_8000);
        chk("and", rf(14), 32'hFFFF_8000);

        chk("stores_all_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
